hsci_mdec_pkt: RTL and testbench
================================

Name: hsci_mdec_pkt

Overview:
- Parametrised next-generation HSCI MISO frame decoder.
- Consumes 10-bit subframes from the MISO frame detector and decodes READ_ACK, ERR_MSG and ALINK frames.
- Packs read-data bytes into DATA_W-wide words with byte strobes for the readback DPRAM.
- Over the previous decoder it adds: configurable word, address and index widths; partial-word handling per transfer mode; read-length checking; address-overflow protection; an inter-byte timeout.

Parameters:
- DATA_W, 32, DPRAM word width; multiple of 8, 16..128.
- ADDR_W, 15, DPRAM word-address width.
- INDEX_BYTES, 4, number of index bytes in a READ_ACK frame; 1..4.
- TIMEOUT, 1024, hsci_pclk cycles without mdec_val mid-frame before abort; 0 disables.

Ports:
- hsci_pclk  in  1  clock
- rstn  in  1  async active-low reset
- mdec_sfrm  in  10  subframe {byte[7:0], par, cont}
- mdec_val  in  1  subframe valid, one cycle per subframe
- miso_test_mode  in  1  test mode; decode suppressed
- man_linkup  in  1  manual linkup; all frames ignored
- auto_linkup  in  1  auto linkup; only ALINK decoded
- ver_b_na  in  1  silicon rev B; enables tx_clk fields
- read_op  in  1  pulse: new read transaction started by encoder
- read_byte_num  in  17  expected data bytes minus 1
- xfer_mode  in  1  0 contiguous, 1 frame-aligned (discontiguous)
- clear_errors  in  1  clears sticky errors
- dec_en  out  1  DPRAM write enable
- dec_we  out  DATA_W/8  byte-lane strobe, one-hot
- dec_addr  out  ADDR_W  DPRAM word address
- dec_data  out  DATA_W  byte in strobed lane, other lanes 0
- read_done  out  1  one-cycle pulse: expected byte count received
- rd_tsize  out  2  tsize field of last READ_ACK instruction
- rd_index  out  8*INDEX_BYTES  index of last READ_ACK, LSB byte first
- dec_fsm  out  3  state encoding
- error_code  out  8  last ERR_MSG payload, sticky
- parity_err, unk_instr_err, timeout_err, overflow_err, len_err  out  1 each  sticky errors
- alink_dval  out  1  ALINK byte valid
- alink_data  out  8  ALINK byte
- signal_acquired  out  1  ALINK frame seen
- tx_clk_adj_rcvd  out  4  tx clock adjust from ALINK instruction
- tx_clk_inv_rcvd  out  1  tx clock invert from ALINK instruction
- idle_state  out  1  (state==D_IDLE) & auto_linkup

Behaviour:
- Reset: all outputs 0; state D_IDLE.
- Instruction byte fields: bit7 = start; bits6:3 = opcode (READ_ACK 1010, ERR_MSG 1100, ALINK 0101); bits1:0 = tsize.
- State encoding: IDLE=0, RINDEX=2, RDATA=3, ERROR=4, LINKUP=5, TMODE=6, MERR=7; 1 unused and recovers to IDLE.
- IDLE, on mdec_val, first matching rule wins:
  - miso_test_mode -> TMODE.
  - man_linkup -> stay.
  - auto_linkup -> LINKUP on start+ALINK, else stay.
  - start+READ_ACK -> RINDEX; latch rd_tsize; clear rd_index.
  - start+ERR_MSG -> ERROR.
  - start+other opcode -> MERR.
  - no start -> stay.
- ALINK instruction with ver_b_na=1: latch tx_clk_adj_rcvd={byte[1:0],par,cont} and tx_clk_inv_rcvd=byte[2]. With ver_b_na=0 both held at 0.
- RINDEX:
  - Each valid byte loads rd_index byte k (k=0..INDEX_BYTES-1).
  - Bytes beyond INDEX_BYTES are ignored.
  - Move to RDATA after INDEX_BYTES bytes, or earlier if cont=0.
- RDATA, each valid byte:
  - Byte is written next cycle: dec_en=1, dec_we=1<<lane, byte placed at lane*8.
  - lane increments. When lane wraps from DATA_W/8-1 to 0, dec_addr increments in the cycle after the write.
  - cont=0 ends the frame -> IDLE.
- End of frame with lane!=0:
  - xfer_mode=1: dec_addr+1, lane=0.
  - xfer_mode=0: position kept so the next frame continues.
- read_op: dec_addr=0, lane=0, byte_cnt=0, read_done=0. read_op takes priority over a simultaneous data byte; that byte is counted and written after the reset.
- byte_cnt reaches read_byte_num+1: read_done pulses 1 cycle after the write of the last byte.
- Data bytes after the count is reached: dropped (no dec_en), len_err set.
- Frame ending short of the count: no error; the count continues on the next frame.
- Address overflow: a byte that would need dec_addr to increment past 2^ADDR_W-1 is still written; the increment does not happen; overflow_err is set; all further writes are suppressed until read_op.
- LINKUP:
  - signal_acquired=1, sticky until auto_linkup=0.
  - Each valid byte: alink_dval=1 for 1 cycle with alink_data.
  - cont=0 -> IDLE.
- ERROR: the next valid byte goes to error_code -> IDLE.
- MERR: the next valid byte sets unk_instr_err -> IDLE.
- TMODE: exit to IDLE when miso_test_mode=0.
- Parity: on every mdec_val, parity_err is set if par != XOR(byte,cont).
- Timeout: in RINDEX, RDATA, LINKUP, ERROR or MERR, a counter counts cycles without mdec_val and clears on mdec_val. When it reaches TIMEOUT: set timeout_err, go to IDLE, do not pulse read_done.
- Sticky errors: a set event in the same cycle as clear_errors wins.
- Async reset mid-frame: all state cleared immediately.

Test Plan:
- DATA_W=32, read_op, read_byte_num=5; READ_ACK frame with 4 index bytes 11,22,33,44 and data A0..A5 -> rd_index=44332211; writes at addr0 lanes 0-3, addr1 lanes 0-1; read_done one pulse after A5.
- xfer_mode=1, read_byte_num=3; two frames of 2 bytes -> second frame written at addr1 lanes 0-1. Repeat with xfer_mode=0 -> addr0 lanes 2-3.
- read_byte_num=1; frame of 3 data bytes -> 2 writes, third byte dropped, len_err=1; clear_errors -> 0.
- ADDR_W=2, DATA_W=16; 10 data bytes -> addr stops at 3, overflow_err=1, only 8 writes occur.
- auto_linkup=1, ver_b_na=1; ALINK instruction 0xAF with par=1, cont=1, then byte 0x5A with cont=0 -> tx_clk_adj_rcvd=1111, tx_clk_inv_rcvd=1, alink_data=5A, signal_acquired=1.
- TIMEOUT=16; stall 16 cycles in RDATA -> timeout_err=1, state returns to IDLE, no read_done. Separately, bad parity on one byte -> parity_err=1; ERR_MSG followed by 0x3C -> error_code=3C.

Source files
------------

// File: rtl/hsci_mdec_pkt_if.sv
// MISO subframe input and readback-DPRAM write port of the HSCI frame decoder.
interface hsci_mdec_pkt_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
);
    logic [9:0]          mdec_sfrm;
    logic                mdec_val;
    logic                dec_en;
    logic [DATA_W/8-1:0] dec_we;
    logic [ADDR_W-1:0]   dec_addr;
    logic [DATA_W-1:0]   dec_data;

    // Frame detector / DPRAM side
    modport master (
        output mdec_sfrm, mdec_val,
        input  dec_en, dec_we, dec_addr, dec_data
    );

    // Decoder side
    modport slave (
        input  mdec_sfrm, mdec_val,
        output dec_en, dec_we, dec_addr, dec_data
    );
endinterface

// File: rtl/hsci_mdec_pkt.sv
// HSCI MISO frame decoder: READ_ACK / ERR_MSG / ALINK frames, read-data byte
// packing into DPRAM words with byte strobes, and sticky error reporting.
module hsci_mdec_pkt #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 15,
    parameter int INDEX_BYTES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     hsci_pclk,
    input  logic                     rstn,
    hsci_mdec_pkt_if.slave           mdec,
    input  logic                     miso_test_mode,
    input  logic                     man_linkup,
    input  logic                     auto_linkup,
    input  logic                     ver_b_na,
    input  logic                     read_op,
    input  logic [16:0]              read_byte_num,
    input  logic                     xfer_mode,
    input  logic                     clear_errors,
    output logic                     read_done,
    output logic [1:0]               rd_tsize,
    output logic [8*INDEX_BYTES-1:0] rd_index,
    output logic [2:0]               dec_fsm,
    output logic [7:0]               error_code,
    output logic                     parity_err,
    output logic                     unk_instr_err,
    output logic                     timeout_err,
    output logic                     overflow_err,
    output logic                     len_err,
    output logic                     alink_dval,
    output logic [7:0]               alink_data,
    output logic                     signal_acquired,
    output logic [3:0]               tx_clk_adj_rcvd,
    output logic                     tx_clk_inv_rcvd,
    output logic                     idle_state
);
    localparam int NL     = DATA_W / 8;
    localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;
    localparam int IDX_W  = $clog2(INDEX_BYTES + 1);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    localparam logic [3:0] OP_READ_ACK = 4'b1010;
    localparam logic [3:0] OP_ERR_MSG  = 4'b1100;
    localparam logic [3:0] OP_ALINK    = 4'b0101;

    typedef enum logic [2:0] {
        D_IDLE   = 3'd0,
        D_RINDEX = 3'd2,
        D_RDATA  = 3'd3,
        D_ERROR  = 3'd4,
        D_LINKUP = 3'd5,
        D_TMODE  = 3'd6,
        D_MERR   = 3'd7
    } dec_state_t;

    dec_state_t          state;
    logic [IDX_W-1:0]    idx_q;
    logic [LANE_W-1:0]   lane_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [17:0]         byte_cnt;
    logic                ovf_lock;
    logic                done_pend;
    logic [TO_W-1:0]     to_cnt;
    logic                dec_en_q;
    logic [NL-1:0]       dec_we_q;
    logic [ADDR_W-1:0]   dec_addr_q;
    logic [DATA_W-1:0]   dec_data_q;

    logic [7:0]          sb_byte;
    logic                sb_par, sb_cont, val, is_start, par_bad;
    logic [3:0]          opc;
    logic                data_byte, cnt_ok, cnt_last, eff_lock, lane_last;
    logic                frame_align, need_inc, addr_max, timed_state, to_hit;
    logic [17:0]         eff_cnt;
    logic [LANE_W-1:0]   eff_lane, lane_nxt;
    logic [ADDR_W-1:0]   eff_addr;

    assign mdec.dec_en   = dec_en_q;
    assign mdec.dec_we   = dec_we_q;
    assign mdec.dec_addr = dec_addr_q;
    assign mdec.dec_data = dec_data_q;
    assign dec_fsm       = state;
    assign idle_state    = (state == D_IDLE) && auto_linkup;

    // Subframe fields and write-position arithmetic; a read_op in the same
    // cycle as a data byte makes the byte land at the freshly reset position.
    always_comb begin
        sb_byte     = mdec.mdec_sfrm[9:2];
        sb_par      = mdec.mdec_sfrm[1];
        sb_cont     = mdec.mdec_sfrm[0];
        val         = mdec.mdec_val;
        is_start    = sb_byte[7];
        opc         = sb_byte[6:3];
        par_bad     = val && (sb_par != ^{sb_byte, sb_cont});
        data_byte   = val && (state == D_RDATA);
        eff_cnt     = read_op ? '0 : byte_cnt;
        eff_lane    = read_op ? '0 : lane_q;
        eff_addr    = read_op ? '0 : addr_q;
        eff_lock    = read_op ? 1'b0 : ovf_lock;
        cnt_ok      = eff_cnt < ({1'b0, read_byte_num} + 18'd1);
        cnt_last    = eff_cnt == {1'b0, read_byte_num};
        lane_last   = eff_lane == LANE_W'(NL - 1);
        lane_nxt    = lane_last ? '0 : eff_lane + 1'b1;
        frame_align = !sb_cont && xfer_mode;
        need_inc    = lane_last || frame_align;
        addr_max    = &eff_addr;
        timed_state = state inside {D_RINDEX, D_RDATA, D_LINKUP, D_ERROR, D_MERR};
        to_hit      = (TIMEOUT != 0) && timed_state && !val && (to_cnt == TO_LAST);
    end

    // Frame FSM, DPRAM write port, ALINK capture and sticky error flags.
    always_ff @(posedge hsci_pclk or negedge rstn) begin
        if (!rstn) begin
            state           <= D_IDLE;
            idx_q           <= '0;
            lane_q          <= '0;
            addr_q          <= '0;
            byte_cnt        <= '0;
            ovf_lock        <= 1'b0;
            done_pend       <= 1'b0;
            to_cnt          <= '0;
            dec_en_q        <= 1'b0;
            dec_we_q        <= '0;
            dec_addr_q      <= '0;
            dec_data_q      <= '0;
            read_done       <= 1'b0;
            rd_tsize        <= '0;
            rd_index        <= '0;
            error_code      <= '0;
            parity_err      <= 1'b0;
            unk_instr_err   <= 1'b0;
            timeout_err     <= 1'b0;
            overflow_err    <= 1'b0;
            len_err         <= 1'b0;
            alink_dval      <= 1'b0;
            alink_data      <= '0;
            signal_acquired <= 1'b0;
            tx_clk_adj_rcvd <= '0;
            tx_clk_inv_rcvd <= 1'b0;
        end else begin
            dec_en_q   <= 1'b0;
            dec_we_q   <= '0;
            dec_data_q <= '0;
            // dec_addr trails the internal pointer so a word-boundary
            // increment shows up the cycle after the write that caused it.
            dec_addr_q <= addr_q;
            read_done  <= done_pend;
            done_pend  <= 1'b0;
            alink_dval <= 1'b0;

            if (read_op) begin
                addr_q     <= '0;
                lane_q     <= '0;
                byte_cnt   <= '0;
                ovf_lock   <= 1'b0;
                read_done  <= 1'b0;
                dec_addr_q <= '0;
            end

            if (data_byte && cnt_ok) begin
                byte_cnt  <= eff_cnt + 18'd1;
                done_pend <= cnt_last;
                if (!eff_lock) begin
                    dec_en_q   <= 1'b1;
                    dec_we_q   <= {{(NL-1){1'b0}}, 1'b1} << eff_lane;
                    dec_data_q <= {{(DATA_W-8){1'b0}}, sb_byte} << {eff_lane, 3'b000};
                    lane_q     <= frame_align ? '0 : lane_nxt;
                    if (need_inc) begin
                        if (addr_max) ovf_lock <= 1'b1;
                        else          addr_q   <= eff_addr + 1'b1;
                    end
                end
            end

            if (!auto_linkup) signal_acquired <= 1'b0;
            if (!ver_b_na) begin
                tx_clk_adj_rcvd <= '0;
                tx_clk_inv_rcvd <= 1'b0;
            end

            if (timed_state && !val) to_cnt <= to_hit ? '0 : to_cnt + 1'b1;
            else                     to_cnt <= '0;

            case (state)
                D_IDLE: if (val) begin
                    if (miso_test_mode) begin
                        state <= D_TMODE;
                    end else if (man_linkup) begin
                        state <= D_IDLE;
                    end else if (auto_linkup) begin
                        if (is_start && opc == OP_ALINK) begin
                            state           <= D_LINKUP;
                            signal_acquired <= 1'b1;
                            if (ver_b_na) begin
                                tx_clk_adj_rcvd <= {sb_byte[1:0], sb_par, sb_cont};
                                tx_clk_inv_rcvd <= sb_byte[2];
                            end
                        end
                    end else if (is_start) begin
                        case (opc)
                            OP_READ_ACK: begin
                                state    <= D_RINDEX;
                                rd_tsize <= sb_byte[1:0];
                                rd_index <= '0;
                                idx_q    <= '0;
                            end
                            OP_ERR_MSG: state <= D_ERROR;
                            default:    state <= D_MERR;
                        endcase
                    end
                end
                D_RINDEX: if (val) begin
                    for (int unsigned k = 0; k < INDEX_BYTES; k++)
                        if (idx_q == IDX_W'(k)) rd_index[k*8 +: 8] <= sb_byte;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(INDEX_BYTES - 1) || !sb_cont) state <= D_RDATA;
                end
                D_RDATA: if (val && !sb_cont) state <= D_IDLE;
                D_LINKUP: if (val) begin
                    alink_dval <= 1'b1;
                    alink_data <= sb_byte;
                    if (!sb_cont) state <= D_IDLE;
                end
                D_ERROR: if (val) begin
                    error_code <= sb_byte;
                    state      <= D_IDLE;
                end
                D_MERR:  if (val) state <= D_IDLE;
                D_TMODE: if (!miso_test_mode) state <= D_IDLE;
                default: state <= D_IDLE;
            endcase

            if (to_hit) begin
                state     <= D_IDLE;
                done_pend <= 1'b0;
            end

            // Set events beat a simultaneous clear.
            parity_err    <= par_bad | (parity_err & ~clear_errors);
            unk_instr_err <= (val && state == D_MERR) | (unk_instr_err & ~clear_errors);
            timeout_err   <= to_hit | (timeout_err & ~clear_errors);
            len_err       <= (data_byte && !cnt_ok) | (len_err & ~clear_errors);
            overflow_err  <= (data_byte && cnt_ok && !eff_lock && need_inc && addr_max)
                           | (overflow_err & ~clear_errors);
        end
    end
endmodule

// File: tb/tb_hsci_mdec_pkt.sv
// Scoreboard bench: two decoders (32-bit/15-bit address and 16-bit/2-bit
// address) share one subframe stream; a byte-position model predicts writes.
module tb_hsci_mdec_pkt;
    localparam int NL0 = 4, CAP0 = 4 * 32768;
    localparam int NL1 = 2, CAP1 = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  sfrm = '0;
    logic        val = 1'b0, tmode = 1'b0, man_lk = 1'b0, auto_lk = 1'b0, verb = 1'b0;
    logic        rop = 1'b0, xmode = 1'b0, clr = 1'b0;
    logic [16:0] rbn = '0;

    hsci_mdec_pkt_if #(.DATA_W(32), .ADDR_W(15)) bus0 ();
    hsci_mdec_pkt_if #(.DATA_W(16), .ADDR_W(2))  bus1 ();
    assign bus0.mdec_sfrm = sfrm;
    assign bus0.mdec_val  = val;
    assign bus1.mdec_sfrm = sfrm;
    assign bus1.mdec_val  = val;

    logic        r0_done, r1_done, r0_txinv, r1_txinv, r0_idle, r1_idle;
    logic [1:0]  r0_tsize, r1_tsize;
    logic [31:0] r0_index, r1_index;
    logic [2:0]  r0_fsm, r1_fsm;
    logic [7:0]  r0_code, r1_code, r0_adata, r1_adata;
    logic        r0_perr, r0_uerr, r0_terr, r0_oerr, r0_lerr, r0_adval, r0_sacq;
    logic        r1_perr, r1_uerr, r1_terr, r1_oerr, r1_lerr, r1_adval, r1_sacq;
    logic [3:0]  r0_txadj, r1_txadj;

    hsci_mdec_pkt #(.DATA_W(32), .ADDR_W(15), .INDEX_BYTES(4), .TIMEOUT(16)) u_dut0 (
        .hsci_pclk(clk), .rstn(rstn), .mdec(bus0), .miso_test_mode(tmode),
        .man_linkup(man_lk), .auto_linkup(auto_lk), .ver_b_na(verb), .read_op(rop),
        .read_byte_num(rbn), .xfer_mode(xmode), .clear_errors(clr), .read_done(r0_done),
        .rd_tsize(r0_tsize), .rd_index(r0_index), .dec_fsm(r0_fsm), .error_code(r0_code),
        .parity_err(r0_perr), .unk_instr_err(r0_uerr), .timeout_err(r0_terr),
        .overflow_err(r0_oerr), .len_err(r0_lerr), .alink_dval(r0_adval), .alink_data(r0_adata),
        .signal_acquired(r0_sacq), .tx_clk_adj_rcvd(r0_txadj), .tx_clk_inv_rcvd(r0_txinv),
        .idle_state(r0_idle));

    hsci_mdec_pkt #(.DATA_W(16), .ADDR_W(2), .INDEX_BYTES(4), .TIMEOUT(16)) u_dut1 (
        .hsci_pclk(clk), .rstn(rstn), .mdec(bus1), .miso_test_mode(tmode),
        .man_linkup(man_lk), .auto_linkup(auto_lk), .ver_b_na(verb), .read_op(rop),
        .read_byte_num(rbn), .xfer_mode(xmode), .clear_errors(clr), .read_done(r1_done),
        .rd_tsize(r1_tsize), .rd_index(r1_index), .dec_fsm(r1_fsm), .error_code(r1_code),
        .parity_err(r1_perr), .unk_instr_err(r1_uerr), .timeout_err(r1_terr),
        .overflow_err(r1_oerr), .len_err(r1_lerr), .alink_dval(r1_adval), .alink_data(r1_adata),
        .signal_acquired(r1_sacq), .tx_clk_adj_rcvd(r1_txadj), .tx_clk_inv_rcvd(r1_txinv),
        .idle_state(r1_idle));

    typedef struct {
        int unsigned addr;
        int unsigned lane;
        logic [7:0]  data;
    } wr_t;

    wr_t wq0[$], wq1[$];
    bit  dq0[$], dq1[$];
    int  n_checks = 0, n_fail = 0, n_alink = 0;
    bit  prev_en0 = 1'b0, prev_en1 = 1'b0;

    // Reference model: absolute byte positions per decoder plus expected flags.
    int unsigned m_pos[2], m_cnt, m_num;
    bit          m_mode, m_lock[2], e_ovf[2], e_len, e_par, e_to, e_unk;
    logic [7:0]  e_code;
    logic [31:0] e_index;
    logic [1:0]  e_tsize;
    int          max_gap = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write/done monitor for the 32-bit decoder.
    always @(negedge clk) begin
        wr_t w;
        if (bus0.dec_en) begin
            check("wr0_expected", 64'(wq0.size() > 0), 64'd1);
            if (wq0.size() > 0) begin
                w = wq0.pop_front();
                check("wr0_addr", 64'(bus0.dec_addr), 64'(w.addr));
                check("wr0_we", 64'(bus0.dec_we), 64'd1 << w.lane);
                check("wr0_data", 64'(bus0.dec_data), 64'(w.data) << (8 * w.lane));
            end
        end
        if (r0_done) begin
            check("done0_expected", 64'(dq0.size() > 0), 64'd1);
            if (dq0.size() > 0) check("done0_after_write", 64'(prev_en0), 64'(dq0.pop_front()));
        end
        if (r0_adval) n_alink++;
        prev_en0 = bus0.dec_en;
    end

    // Write/done monitor for the 16-bit, 4-word decoder.
    always @(negedge clk) begin
        wr_t w;
        if (bus1.dec_en) begin
            check("wr1_expected", 64'(wq1.size() > 0), 64'd1);
            if (wq1.size() > 0) begin
                w = wq1.pop_front();
                check("wr1_addr", 64'(bus1.dec_addr), 64'(w.addr));
                check("wr1_we", 64'(bus1.dec_we), 64'd1 << w.lane);
                check("wr1_data", 64'(bus1.dec_data), 64'(w.data) << (8 * w.lane));
            end
        end
        if (r1_done) begin
            check("done1_expected", 64'(dq1.size() > 0), 64'd1);
            if (dq1.size() > 0) check("done1_after_write", 64'(prev_en1), 64'(dq1.pop_front()));
        end
        prev_en1 = bus1.dec_en;
    end

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_sf(input logic [7:0] b, input bit c, input bit bad_par);
        sfrm = {b, (^{b, c}) ^ bad_par, c};
        val  = 1'b1;
        @(posedge clk); #1;
        val  = 1'b0;
    endtask

    task automatic do_read_op(input int unsigned num, input bit mode);
        rbn = 17'(num); xmode = mode; rop = 1'b1;
        gap(1);
        rop = 1'b0;
        m_num = num; m_mode = mode; m_cnt = 0;
        for (int d = 0; d < 2; d++) begin m_pos[d] = 0; m_lock[d] = 1'b0; end
    endtask

    task automatic clear_errs();
        clr = 1'b1; gap(1); clr = 1'b0;
        e_len = 0; e_par = 0; e_to = 0; e_unk = 0; e_ovf[0] = 0; e_ovf[1] = 0;
    endtask

    task automatic model_data(input logic [7:0] b, input bit last);
        int unsigned nl, cap, nxt;
        bit wrote;
        wr_t w;
        if (m_cnt >= m_num + 1) begin e_len = 1'b1; return; end
        m_cnt++;
        for (int d = 0; d < 2; d++) begin
            nl = (d == 0) ? NL0 : NL1;
            cap = (d == 0) ? CAP0 : CAP1;
            wrote = !m_lock[d];
            if (wrote) begin
                w.addr = m_pos[d] / nl; w.lane = m_pos[d] % nl; w.data = b;
                if (d == 0) wq0.push_back(w); else wq1.push_back(w);
                nxt = m_pos[d] + 1;
                if (last && m_mode && (nxt % nl) != 0) nxt += nl - (nxt % nl);
                if (nxt >= cap) begin m_lock[d] = 1'b1; e_ovf[d] = 1'b1; end
                else m_pos[d] = nxt;
            end
            if (m_cnt == m_num + 1) begin
                if (d == 0) dq0.push_back(wrote); else dq1.push_back(wrote);
            end
        end
    endtask

    // READ_ACK frame from a byte queue; 'term' ends the frame on the last byte.
    task automatic send_readack(input logic [1:0] tsz, input logic [31:0] idx,
                                input logic [7:0] data[$], input bit term);
        bit last;
        send_sf({1'b1, 4'b1010, 1'b0, tsz}, 1'b1, 1'b0);
        e_tsize = tsz; e_index = idx;
        for (int k = 0; k < 4; k++) begin
            send_sf(idx[k*8 +: 8], 1'b1, 1'b0);
            gap($urandom_range(max_gap, 0));
        end
        for (int i = 0; i < data.size(); i++) begin
            last = term && (i == data.size() - 1);
            model_data(data[i], last);
            send_sf(data[i], !last, 1'b0);
            gap($urandom_range(max_gap, 0));
        end
    endtask

    task automatic checkpoint(input string tag);
        gap(4);
        check({tag, "_wq0_drained"}, 64'(wq0.size()), 64'd0);
        check({tag, "_wq1_drained"}, 64'(wq1.size()), 64'd0);
        check({tag, "_done0_drained"}, 64'(dq0.size()), 64'd0);
        check({tag, "_done1_drained"}, 64'(dq1.size()), 64'd0);
        check({tag, "_fsm"}, 64'(r0_fsm), 64'd0);
        check({tag, "_addr0"}, 64'(bus0.dec_addr), 64'(m_pos[0] / NL0));
        check({tag, "_addr1"}, 64'(bus1.dec_addr), 64'(m_pos[1] / NL1));
        check({tag, "_len_err"}, 64'(r0_lerr), 64'(e_len));
        check({tag, "_ovf0"}, 64'(r0_oerr), 64'(e_ovf[0]));
        check({tag, "_ovf1"}, 64'(r1_oerr), 64'(e_ovf[1]));
        check({tag, "_par"}, 64'(r0_perr), 64'(e_par));
        check({tag, "_to"}, 64'(r0_terr), 64'(e_to));
        check({tag, "_unk"}, 64'(r0_uerr), 64'(e_unk));
        check({tag, "_index"}, 64'(r0_index), 64'(e_index));
        check({tag, "_tsize"}, 64'(r0_tsize), 64'(e_tsize));
        check({tag, "_code"}, 64'(r0_code), 64'(e_code));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        int unsigned nfr, nb;
        e_code = '0; e_index = '0; e_tsize = '0;
        e_len = 0; e_par = 0; e_to = 0; e_unk = 0; e_ovf[0] = 0; e_ovf[1] = 0;
        m_pos[0] = 0; m_pos[1] = 0; m_cnt = 0; m_num = 0; m_mode = 0;
        m_lock[0] = 0; m_lock[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_fsm", 64'(r0_fsm), 64'd0);
        check("rst_dec_en", 64'(bus0.dec_en), 64'd0);
        check("rst_read_done", 64'(r0_done), 64'd0);
        rstn = 1'b1;
        gap(2);
        checkpoint("reset");

        // Contiguous packing, 4 index bytes, read_done one cycle after last write
        do_read_op(5, 1'b0);
        d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_readack(2'd2, 32'h4433_2211, d, 1'b1);
        checkpoint("basic");
        check("basic_index_value", 64'(r0_index), 64'h4433_2211);

        // Frame-aligned vs contiguous continuation across two frames
        for (int m = 1; m >= 0; m--) begin
            do_read_op(3, m[0]);
            d = '{8'h10, 8'h11};
            send_readack(2'd1, $urandom, d, 1'b1);
            gap(2);
            d = '{8'h12, 8'h13};
            send_readack(2'd1, $urandom, d, 1'b1);
            checkpoint(m[0] ? "xfer_aligned" : "xfer_contig");
        end

        // Excess bytes dropped with len_err, then cleared
        do_read_op(1, 1'b0);
        d = '{8'h21, 8'h22, 8'h23};
        send_readack(2'd0, 32'h0102_0304, d, 1'b1);
        checkpoint("len");
        clear_errs();
        checkpoint("len_clr");

        // 10 bytes: the 4-word decoder overflows after 8 writes
        do_read_op(9, 1'b0);
        d = '{};
        for (int i = 0; i < 10; i++) d.push_back(8'(8'h30 + i));
        send_readack(2'd3, 32'hDEAD_BEEF, d, 1'b1);
        checkpoint("ovf");
        check("ovf_addr1_stuck", 64'(bus1.dec_addr), 64'd3);
        clear_errs();

        // ALINK in auto-linkup mode with rev-B tx clock fields
        auto_lk = 1'b1; verb = 1'b1;
        gap(1);
        send_sf(8'hAF, 1'b1, 1'b0);
        send_sf(8'h5A, 1'b0, 1'b0);
        gap(3);
        check("alink_adj", 64'(r0_txadj), 64'hF);
        check("alink_inv", 64'(r0_txinv), 64'd1);
        check("alink_data", 64'(r0_adata), 64'h5A);
        check("alink_pulses", 64'(n_alink), 64'd1);
        check("alink_acq", 64'(r0_sacq), 64'd1);
        check("alink_idle_state", 64'(r0_idle), 64'd1);
        auto_lk = 1'b0; verb = 1'b0;
        gap(2);
        check("alink_acq_drop", 64'(r0_sacq), 64'd0);
        check("alink_adj_drop", 64'(r0_txadj), 64'd0);
        checkpoint("alink");

        // Mid-frame stall in RDATA hits the inter-byte timeout
        do_read_op(10, 1'b0);
        d = '{8'h55, 8'h66};
        send_readack(2'd0, 32'h0A0B_0C0D, d, 1'b0);
        gap(20);
        e_to = 1'b1;
        checkpoint("timeout");
        clear_errs();

        // ERR_MSG payload, bad parity on a loose byte, unknown opcode
        send_sf(8'hE0, 1'b1, 1'b0);
        send_sf(8'h3C, 1'b0, 1'b0);
        e_code = 8'h3C;
        checkpoint("errmsg");
        send_sf(8'h12, 1'b0, 1'b1);
        e_par = 1'b1;
        checkpoint("parity");
        send_sf(8'h80, 1'b1, 1'b0);
        send_sf(8'h00, 1'b0, 1'b0);
        e_unk = 1'b1;
        checkpoint("unknown");
        clear_errs();

        // Randomised transactions
        max_gap = 3;
        for (int it = 0; it < 25; it++) begin
            clear_errs();
            do_read_op($urandom_range(24, 0), 1'($urandom_range(1, 0)));
            nfr = $urandom_range(3, 1);
            for (int f = 0; f < int'(nfr); f++) begin
                nb = $urandom_range(8, 1);
                d = '{};
                for (int i = 0; i < int'(nb); i++) d.push_back(8'($urandom));
                send_readack(2'($urandom), $urandom, d, 1'b1);
                gap($urandom_range(3, 0));
            end
            checkpoint("rand");
        end

        // Asynchronous reset in the middle of a frame
        send_sf(8'hD3, 1'b1, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("areset_fsm", 64'(r0_fsm), 64'd0);
        check("areset_tsize", 64'(r0_tsize), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
